byte_pack_write_memory: RTL
===========================

Name: byte_pack_write_memory

Overview:
- Write-side counterpart of the word-organised, byte-addressed read memory used for input data.
- Accepts a stream of result bytes over a valid/ready handshake and packs every 4 bytes into one 32-bit word, byte lane 0 in bits [31:24] and lane 3 in [7:0]. This matches the read memory's byte ordering.
- Stores the packed words at consecutive word addresses from a latched base byte-address.
- On completion, raises a done pulse and dumps memory to FILE_NAME in hex in simulation. A combinational read-back port mirrors the read memory's output format.

Parameters:
- CAPACITY, 256: number of 32-bit words in the storage array.
- NO_BITS, 10: byte-address width; word index = addr >> 2.
- PAD, 8'h00: fill byte for unused lanes of a partial final word.
- FILE_NAME, "output.txt": $writememh target on completion (simulation only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- base_addr  in  NO_BITS  starting byte address; bits [1:0] ignored (word-aligned).
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_last  in  1  qualifies the final byte of the transfer.
- in_ready  out  1  block can accept a byte.
- done  out  1  one-cycle pulse at transfer end.
- byte_count  out  NO_BITS  bytes accepted in the current/last transfer.
- wrapped  out  1  sticky: word pointer wrapped past CAPACITY-1 in this transfer.
- rd_addr  in  NO_BITS  read-back byte address.
- rd_data  out  8 x [0:3]  unpacked array; rd_data[0]=word[31:24] … rd_data[3]=word[7:0] of mem[rd_addr>>2]; combinational.

Behaviour:
- Reset (async assert, sync-released use):
  - State IDLE; in_ready=0, done=0, byte_count=0, wrapped=0.
  - Lane=0, word_ptr=0, assembly register=0.
  - Memory contents not cleared.
- FSM states: IDLE, ACCEPT, FLUSH, DONE.
- IDLE:
  - On start=1: word_ptr<=base_addr>>2, lane<=0, byte_count<=0, wrapped<=0, go to ACCEPT.
  - in_ready=0.
- ACCEPT:
  - in_ready=1. A handshake is in_valid & in_ready; with no handshake, state holds.
  - On handshake: byte_count+1. Byte goes into assembly lane `lane` (lane 0 → [31:24]); lane increments mod 4.
  - Handshake with lane==3: mem[word_ptr] <= {assembly[31:8], in_data} at the same edge.
  - Then word_ptr increments. From CAPACITY-1 it wraps to 0 and wrapped<=1.
- End of transfer in ACCEPT:
  - in_last with lane==3: word written as above; next state DONE.
  - in_last with lane<3: next state FLUSH.
- FLUSH (exactly 1 cycle):
  - in_ready=0.
  - mem[word_ptr] <= assembled bytes, remaining lanes = PAD.
  - word_ptr increments (same wrap rule). Next state DONE.
- DONE (exactly 1 cycle):
  - done=1, in_ready=0; $writememh(FILE_NAME, mem) in simulation. Next state IDLE.
- byte_count and wrapped hold after DONE until the next start.
- Latency: a word is visible on rd_data the cycle after the edge that writes it.
- start outside IDLE is ignored. in_last without in_valid is ignored.
- in_valid while in_ready=0: byte not consumed; source must hold it.
- Reset mid-transfer: returns to IDLE immediately. Already-written words remain; the partial assembly is discarded; no done pulse.
- byte_count wraps modulo 2^NO_BITS; no saturation.

Test Plan:
- Reset with rst_n=0 mid-ACCEPT → next cycle: in_ready=0, done=0, byte_count=0. Earlier-written mem word unchanged on rd_data.
- base_addr=0x010, bytes 0x11,0x22,0x33,0x44 (last on 4th), one per cycle:
  - done pulses 1 cycle after the 4th byte.
  - rd_addr=0x010 → rd_data = {0x11,0x22,0x33,0x44}; byte_count=4.
- base_addr=0x013, 6 bytes 0x01..0x06 with in_last on 6th:
  - FLUSH cycle seen with in_ready=0.
  - mem[4]=0x01020304, mem[5]=0x05060000; byte_count=6; done 2 cycles after last byte.
- Random in_valid gaps: 8 bytes 0xA0..0xA7 → identical memory result to the gap-free case. No byte is lost or duplicated when in_valid is held with in_ready=0.
- CAPACITY=4, base_addr=0x00C, 8 bytes → mem[3]=bytes 0–3, mem[0]=bytes 4–7, wrapped=1.
- Operating conditions:
  - start pulsed during ACCEPT → no restart; byte_count continues.
  - start held high through DONE → a new transfer begins on the IDLE cycle after DONE.

Source files
------------

// File: rtl/byte_pack_write_memory.sv
// byte_pack_write_memory
// Packs a valid/ready stream of bytes into 32-bit words (lane 0 in [31:24],
// lane 3 in [7:0]). Words are stored at consecutive word addresses starting at
// a latched base byte address. A combinational read-back port returns the
// four bytes of a stored word in the same lane order as the read-side memory.

module byte_pack_write_memory #(
  parameter int          CAPACITY  = 256,
  parameter int          NO_BITS   = 10,
  parameter logic [7:0]  PAD       = 8'h00,
  parameter              FILE_NAME = "output.txt"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NO_BITS-1:0] base_addr,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               done,
  output logic [NO_BITS-1:0] byte_count,
  output logic               wrapped,
  input  logic [NO_BITS-1:0] rd_addr,
  output logic [7:0]         rd_data [0:3]
);

  // Word index width; the byte address must be at least IDX_W+2 bits wide.
  localparam int              IDX_W    = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CAPACITY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] word_ptr;
  logic [IDX_W-1:0] word_ptr_inc;
  logic             ptr_at_end;
  logic [1:0]       lane;
  logic [31:0]      assembly;
  logic             hs;
  logic [31:0]      mem [CAPACITY];
  logic [31:0]      rd_word;
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_addr_bits;

  // Byte-offset bits of both addresses carry no meaning for a word store.
  assign unused_addr_bits = ^{base_addr[1:0], rd_addr[1:0]};

  assign base_idx     = base_addr[IDX_W+1:2];
  assign rd_idx       = rd_addr[IDX_W+1:2];
  assign in_ready     = (state == S_ACCEPT);
  assign done         = (state == S_DONE);
  assign hs           = in_valid & in_ready;
  assign ptr_at_end   = (word_ptr == LAST_IDX);
  assign word_ptr_inc = ptr_at_end ? '0 : word_ptr + IDX_W'(1);

  // Keep the first n_lanes assembled bytes and fill the rest with PAD.
  function automatic logic [31:0] pad_word(input logic [31:0] w,
                                           input logic [1:0]  n_lanes);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(n_lanes)) r[8*(3-i) +: 8] = PAD;
    end
    return r;
  endfunction

  // Next-state decode for the transfer sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ACCEPT;
      S_ACCEPT: if (hs && in_last) state_next = (lane == 2'd3) ? S_DONE : S_FLUSH;
      S_FLUSH:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Control and assembly registers: state, pointer, lane, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      word_ptr   <= '0;
      lane       <= 2'd0;
      byte_count <= '0;
      wrapped    <= 1'b0;
      assembly   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            word_ptr   <= base_idx;
            lane       <= 2'd0;
            byte_count <= '0;
            wrapped    <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (hs) begin
            byte_count <= byte_count + NO_BITS'(1);
            lane       <= lane + 2'd1;
            if (lane == 2'd3) begin
              word_ptr <= word_ptr_inc;
              if (ptr_at_end) wrapped <= 1'b1;
            end else begin
              assembly[8*(3-int'(lane)) +: 8] <= in_data;
            end
          end
        end
        S_FLUSH: begin
          word_ptr <= word_ptr_inc;
          if (ptr_at_end) wrapped <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage array writes: full words from ACCEPT, padded partial word from FLUSH.
  always_ff @(posedge clk) begin
    if (hs && (lane == 2'd3)) begin
      mem[word_ptr] <= {assembly[31:8], in_data};
    end else if (state == S_FLUSH) begin
      mem[word_ptr] <= pad_word(assembly, lane);
    end
  end

  // Read-back: split the addressed word into lanes, lane 0 = MSB.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++) begin
      rd_data[i] = rd_word[8*(3-i) +: 8];
    end
  end

endmodule
